fwd_scoreboard: RTL and testbench

- Parametrised successor to the pipeline forwarding unit.
- Keeps a shift-register scoreboard of in-flight writers (EX, MEM, WB, ...).
- Per source operand it produces:
  - registered EX bypass selects;
  - combinational ID-stage branch-compare bypass selects;
  - load-use and branch-use stall requests.
- Sits beside the hazard unit. Operand muxes in ID and EX consume its selects.

---
 rtl/fwd_scoreboard.sv | 133 +++++++++++++
 tb/tb_fwd_scoreboard.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/fwd_scoreboard.sv
// fwd_scoreboard: shift-register scoreboard of in-flight writers producing EX/ID bypass selects and stalls.
// Optional macro FWD_STALL_CNT_EN adds a saturating 16-bit stall_cycles counter.
module fwd_scoreboard #(
    parameter int unsigned REG_AW     = 5,
    parameter int unsigned NUM_SRC    = 2,
    parameter int unsigned DEPTH      = 3,
    parameter int unsigned LOAD_READY = 2,
    localparam int unsigned SW        = $clog2(DEPTH + 1)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      id_valid,
    input  logic [NUM_SRC*REG_AW-1:0] id_src,
    input  logic [NUM_SRC-1:0]        id_src_used,
    input  logic [REG_AW-1:0]         id_rd,
    input  logic                      id_regwrite,
    input  logic                      id_is_load,
    input  logic                      id_is_branch,
    input  logic                      id_flush,
    input  logic                      pipe_hold,
    output logic                      stall,
    output logic [NUM_SRC*SW-1:0]     fwd_ex_sel,
    output logic [NUM_SRC*SW-1:0]     br_fwd_sel
`ifdef FWD_STALL_CNT_EN
    ,
    output logic [15:0]               stall_cycles
`endif
);

    localparam logic [SW-1:0] LAST_K = SW'(DEPTH - 1);
    localparam logic [SW-1:0] LR_K   = SW'(LOAD_READY);
    localparam logic [SW-1:0] ONE_K  = SW'(1);

    logic [DEPTH-1:0]             vld_q;
    logic [DEPTH-1:0]             wen_q;
    logic [DEPTH-1:0]             ld_q;
    logic [DEPTH-1:0][REG_AW-1:0] rd_q;
    logic [NUM_SRC*SW-1:0]        fwd_q;
    logic [NUM_SRC*SW-1:0]        ex_cand;
    logic [NUM_SRC*SW-1:0]        br_sel;
    logic [NUM_SRC-1:0]           lu_haz;
    logic [NUM_SRC-1:0]           br_haz;
    logic                         enter;

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
        logic [REG_AW-1:0]       src;
        logic [DEPTH:0]          c_found;
        logic [DEPTH:0]          c_ld;
        logic [DEPTH:0][SW-1:0]  c_idx;
        logic [SW-1:0]           kp1;
        logic [SW-1:0]           ex_c;
        logic [SW-1:0]           br_s;
        logic                    lu_h;
        logic                    br_h;

        assign src            = id_src[g*REG_AW +: REG_AW];
        assign c_found[DEPTH] = 1'b0;
        assign c_ld[DEPTH]    = 1'b0;
        assign c_idx[DEPTH]   = '0;

        // Priority chain from oldest to youngest: the lowest matching stage wins.
        for (genvar k = 0; k < DEPTH; k++) begin : g_stage
            logic hit;
            assign hit = id_src_used[g] && vld_q[k] && wen_q[k] &&
                         (rd_q[k] == src) && (src != '0);
            assign c_found[k] = hit | c_found[k+1];
            assign c_idx[k]   = hit ? SW'(k) : c_idx[k+1];
            assign c_ld[k]    = hit ? ld_q[k] : c_ld[k+1];
        end

        assign kp1 = c_idx[0] + ONE_K;

        always_comb begin
            ex_c = '0;
            lu_h = 1'b0;
            br_s = '0;
            br_h = 1'b0;
            if (c_found[0]) begin
                // Producer leaving WB has already written the register file.
                if (c_idx[0] != LAST_K) begin
                    if (!c_ld[0] || (kp1 >= LR_K)) ex_c = kp1;
                    else                            lu_h = 1'b1;
                end
                if (id_is_branch) begin
                    if (c_ld[0] ? (c_idx[0] >= LR_K) : (c_idx[0] != '0)) br_s = c_idx[0];
                    else                                                  br_h = 1'b1;
                end
            end
        end

        assign ex_cand[g*SW +: SW] = ex_c;
        assign br_sel[g*SW +: SW]  = br_s;
        assign lu_haz[g]           = lu_h;
        assign br_haz[g]           = br_h;
    end

    assign stall      = id_valid && !id_flush && ((|lu_haz) || (|br_haz));
    assign enter      = id_valid && !id_flush && !stall;
    assign fwd_ex_sel = fwd_q;
    assign br_fwd_sel = br_sel;

    // Scoreboard shift; a stalled or flushed ID slot becomes a bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            wen_q <= '0;
            ld_q  <= '0;
            rd_q  <= '0;
            fwd_q <= '0;
        end else if (!pipe_hold) begin
            vld_q <= {vld_q[DEPTH-2:0], enter};
            wen_q <= {wen_q[DEPTH-2:0], id_regwrite};
            ld_q  <= {ld_q[DEPTH-2:0], id_is_load};
            rd_q  <= {rd_q[DEPTH-2:0], id_rd};
            fwd_q <= enter ? ex_cand : '0;
        end
    end

`ifdef FWD_STALL_CNT_EN
    logic [15:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (stall && !pipe_hold && (cnt_q != 16'hFFFF)) begin
            cnt_q <= cnt_q + 16'd1;
        end
    end

    assign stall_cycles = cnt_q;
`endif

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Scoreboard bench for fwd_scoreboard: stimulus queues expected outputs, a negedge monitor compares.
// A second DEPTH=4/LOAD_READY=3 instance shares the inputs to observe longer load stalls.
module tb_fwd_scoreboard;

    logic        clk;
    logic        rst_n;
    logic        id_valid;
    logic [9:0]  id_src;
    logic [1:0]  id_src_used;
    logic [4:0]  id_rd;
    logic        id_regwrite;
    logic        id_is_load;
    logic        id_is_branch;
    logic        id_flush;
    logic        pipe_hold;
    logic        stall;
    logic [3:0]  fwd_ex_sel;
    logic [3:0]  br_fwd_sel;
    logic        stall2;
    logic [5:0]  fwd2;
    logic [5:0]  br2;
`ifdef FWD_STALL_CNT_EN
    logic [15:0] stall_cycles;
    logic [15:0] stall_cycles2;
`endif

    fwd_scoreboard #(.REG_AW(5), .NUM_SRC(2), .DEPTH(3), .LOAD_READY(2)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_src(id_src),
        .id_src_used(id_src_used), .id_rd(id_rd), .id_regwrite(id_regwrite),
        .id_is_load(id_is_load), .id_is_branch(id_is_branch), .id_flush(id_flush),
        .pipe_hold(pipe_hold), .stall(stall), .fwd_ex_sel(fwd_ex_sel),
        .br_fwd_sel(br_fwd_sel)
`ifdef FWD_STALL_CNT_EN
        , .stall_cycles(stall_cycles)
`endif
    );

    fwd_scoreboard #(.REG_AW(5), .NUM_SRC(2), .DEPTH(4), .LOAD_READY(3)) dut2 (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_src(id_src),
        .id_src_used(id_src_used), .id_rd(id_rd), .id_regwrite(id_regwrite),
        .id_is_load(id_is_load), .id_is_branch(id_is_branch), .id_flush(id_flush),
        .pipe_hold(pipe_hold), .stall(stall2), .fwd_ex_sel(fwd2),
        .br_fwd_sel(br2)
`ifdef FWD_STALL_CNT_EN
        , .stall_cycles(stall_cycles2)
`endif
    );

    typedef struct {
        string      nm;
        logic       es;
        logic [3:0] ef;
        logic [3:0] eb;
        bit         c2;
        logic       e2;
    } exp_t;

    exp_t q[$];
    exp_t cur;
    int   checks = 0;
    int   errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input string fld, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s.%s: got %0d expected %0d", nm, fld, act, exp);
        end
    endtask

    // Monitor: one expected record per cycle, compared away from the active edge.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            cur = q.pop_front();
            chk(cur.nm, "stall", {15'd0, stall}, {15'd0, cur.es});
            chk(cur.nm, "fwd_ex_sel", {12'd0, fwd_ex_sel}, {12'd0, cur.ef});
            chk(cur.nm, "br_fwd_sel", {12'd0, br_fwd_sel}, {12'd0, cur.eb});
            if (cur.c2) chk(cur.nm, "stall_d4", {15'd0, stall2}, {15'd0, cur.e2});
        end
    end

    task automatic ins(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [1:0] used, input logic [4:0] rd,
                       input logic rw, input logic ld, input logic br);
        id_valid     = v;
        id_src       = {rt, rs};
        id_src_used  = used;
        id_rd        = rd;
        id_regwrite  = rw;
        id_is_load   = ld;
        id_is_branch = br;
        id_flush     = 1'b0;
        pipe_hold    = 1'b0;
    endtask

    task automatic cyc(input string nm, input logic es, input logic [3:0] ef,
                       input logic [3:0] eb, input bit c2, input logic e2);
        exp_t r;
        r.nm = nm; r.es = es; r.ef = ef; r.eb = eb; r.c2 = c2; r.e2 = e2;
        q.push_back(r);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        ins(0, 0, 0, 2'b00, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        cyc("reset", 0, 0, 0, 1, 0);
        rst_n = 1'b1;

        // EX-to-EX bypass
        ins(1, 1, 2, 2'b11, 3, 1, 0, 0); cyc("ex_add3", 0, 0, 0, 0, 0);
        ins(1, 3, 5, 2'b11, 4, 1, 0, 0); cyc("ex_sub", 0, 0, 0, 0, 0);
        ins(0, 0, 0, 2'b00, 0, 0, 0, 0); cyc("ex_sel", 0, 4'd1, 0, 0, 0);

        // youngest writer wins, oldest stage gives register file
        ins(1, 0, 0, 2'b00, 3, 1, 0, 0); cyc("pri_w3a", 0, 0, 0, 0, 0);
        ins(1, 0, 0, 2'b00, 3, 1, 0, 0); cyc("pri_w3b", 0, 0, 0, 0, 0);
        ins(1, 3, 0, 2'b01, 0, 0, 0, 0); cyc("pri_use", 0, 0, 0, 0, 0);
        ins(0, 0, 0, 2'b00, 0, 0, 0, 0); cyc("pri_sel", 0, 4'd1, 0, 0, 0);
        ins(1, 3, 0, 2'b01, 0, 0, 0, 0); cyc("wb_use", 0, 0, 0, 0, 0);
        ins(0, 0, 0, 2'b00, 0, 0, 0, 0); cyc("wb_sel0", 0, 0, 0, 0, 0);

        // load-use
        ins(1, 1, 0, 2'b01, 2, 1, 1, 0); cyc("lu_lw", 0, 0, 0, 1, 0);
        ins(1, 2, 2, 2'b11, 6, 1, 0, 0); cyc("lu_stall", 1, 0, 0, 1, 1);
        cyc("lu_go", 0, 0, 0, 1, 1);
        cyc("lu_sel22", 0, 4'd10, 0, 1, 0);
        ins(0, 0, 0, 2'b00, 0, 0, 0, 0); cyc("lu_wb", 0, 0, 0, 1, 0);

        // branch compare after ALU and after load
        ins(1, 0, 0, 2'b00, 1, 1, 0, 0); cyc("br_add1", 0, 0, 0, 0, 0);
        ins(1, 1, 0, 2'b11, 0, 0, 0, 1); cyc("br_alu_stall", 1, 0, 0, 1, 1);
        cyc("br_alu_sel", 0, 0, 4'd1, 1, 0);
        ins(1, 0, 0, 2'b00, 1, 1, 1, 0); cyc("br_lw1", 0, 4'd2, 0, 0, 0);
        ins(1, 1, 1, 2'b11, 0, 0, 0, 1); cyc("br_ld_stall1", 1, 0, 0, 1, 1);
        cyc("br_ld_stall2", 1, 0, 0, 1, 1);
        cyc("br_ld_sel22", 0, 0, 4'd10, 1, 1);
        ins(0, 0, 0, 2'b00, 0, 0, 0, 0); cyc("br_ex_wb", 0, 0, 0, 1, 0);
`ifdef FWD_STALL_CNT_EN
        chk("cnt", "after_branch", stall_cycles, 16'd4);
`endif

        // register 0 never forwards
        ins(1, 0, 0, 2'b00, 0, 1, 0, 0); cyc("r0_add", 0, 0, 0, 0, 0);
        ins(1, 0, 0, 2'b11, 0, 0, 0, 1); cyc("r0_use", 0, 0, 0, 0, 0);
        ins(0, 0, 0, 2'b00, 0, 0, 0, 0); cyc("r0_sel", 0, 0, 0, 0, 0);

        // flush beats hazard and leaves a bubble
        ins(1, 0, 0, 2'b00, 7, 1, 1, 0); cyc("fl_lw", 0, 0, 0, 0, 0);
        ins(1, 7, 0, 2'b01, 8, 1, 0, 0); id_flush = 1'b1;
        cyc("fl_nostall", 0, 0, 0, 1, 0);
        ins(1, 8, 0, 2'b01, 0, 0, 0, 0); cyc("fl_use8", 0, 0, 0, 0, 0);
        ins(0, 0, 0, 2'b00, 0, 0, 0, 0); cyc("fl_bubble", 0, 0, 0, 0, 0);

        // pipe_hold during a load-use stall
        ins(1, 0, 0, 2'b00, 9, 1, 0, 0);  cyc("h_add9", 0, 0, 0, 0, 0);
        ins(1, 9, 0, 2'b01, 10, 1, 1, 0); cyc("h_lw10", 0, 0, 0, 0, 0);
        ins(1, 10, 10, 2'b11, 11, 1, 0, 0); pipe_hold = 1'b1;
        cyc("h_hold1", 1, 4'd1, 0, 0, 0);
        cyc("h_hold2", 1, 4'd1, 0, 0, 0);
        cyc("h_hold3", 1, 4'd1, 0, 0, 0);
`ifdef FWD_STALL_CNT_EN
        chk("cnt", "during_hold", stall_cycles, 16'd4);
`endif
        pipe_hold = 1'b0;
        cyc("h_release", 1, 4'd1, 0, 0, 0);
`ifdef FWD_STALL_CNT_EN
        chk("cnt", "after_hold", stall_cycles, 16'd5);
`endif
        cyc("h_go", 0, 0, 0, 0, 0);
        ins(1, 11, 0, 2'b01, 12, 1, 1, 0); cyc("h_sel22", 0, 4'd10, 0, 0, 0);

        // asynchronous reset in the middle of a held stall
        ins(1, 12, 0, 2'b01, 13, 1, 0, 0); pipe_hold = 1'b1;
        cyc("rs_pre", 1, 4'd1, 0, 0, 0);
        rst_n = 1'b0;
`ifdef FWD_STALL_CNT_EN
        #1;
        chk("cnt", "reset", stall_cycles, 16'd0);
`endif
        cyc("rs_mid", 0, 0, 0, 1, 0);
        rst_n = 1'b1;
        ins(0, 0, 0, 2'b00, 0, 0, 0, 0); cyc("rs_after", 0, 0, 0, 1, 0);

        chk("drain", "queue", 16'(q.size()), 16'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
